// File: rtl/timer_responder_pkg.sv
// Shared definitions for the memory-mapped countdown timer: register offsets,
// CTRL bit positions, FSM encodings and the CTRL register layout.
package timer_responder_pkg;

  // Register offsets, selected by PrAddr[3:2]
  localparam logic [1:0] TMR_CTRL   = 2'd0;
  localparam logic [1:0] TMR_PRESET = 2'd1;
  localparam logic [1:0] TMR_COUNT  = 2'd2;

  // CTRL bit positions
  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;

  // Only 01 reloads; 00 and the reserved 1x codes behave as one-shot
  localparam logic [1:0] MODE_RELOAD = 2'b01;

  typedef enum logic [1:0] {
    TMR_IDLE = 2'd0,
    TMR_LOAD = 2'd1,
    TMR_CNT  = 2'd2,
    TMR_INT  = 2'd3
  } tmr_state_e;

  // Packed so that bit 0 is En, bits 2:1 Mode and bit 3 IM
  typedef struct packed {
    logic       im;
    logic [1:0] mode;
    logic       en;
  } tmr_ctrl_t;

  function automatic logic is_reload(input logic [1:0] mode);
    return mode == MODE_RELOAD;
  endfunction

endpackage

// File: rtl/timer_responder_if.sv
// Bridge bus seen by a timer responder: the CPU side drives address, write
// data and the write strobe; the responder returns read data and its Hit flag.
interface timer_responder_if;
  logic [31:0] PrAddr;
  logic [31:0] PrWD;
  logic        PrWE;
  logic [31:0] PrRD;
  logic        Hit;

  modport master (output PrAddr, output PrWD, output PrWE,
                  input  PrRD,   input  Hit);
  modport slave  (input  PrAddr, input  PrWD, input  PrWE,
                  output PrRD,   output Hit);
endinterface

// File: rtl/timer_responder.sv
// Countdown timer responder on the bridge bus: 16-byte register window at
// BASE_ADDR, combinational reads, clocked writes, and a registered level IRQ.
module timer_responder
  import timer_responder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
  input  logic                clk,
  input  logic                reset,
  timer_responder_if.slave    bus,
  output logic                IRQ
);

  tmr_state_e  state_q, state_d;
  tmr_ctrl_t   ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        pend_q, pend_d;
  logic        irq_q, irq_d;

  logic [1:0]  offs;
  logic        wr_hit;
  logic        wr_ctrl;
  logic        wr_preset;
  logic        fsm_clr_en;
  logic        fsm_set_pend;
  logic [31:0] rd_data;
  logic        unused_addr;

  assign bus.Hit   = (bus.PrAddr[31:4] == BASE_ADDR[31:4]);
  assign offs      = bus.PrAddr[3:2];
  assign wr_hit    = bus.PrWE & bus.Hit;
  assign wr_ctrl   = wr_hit & (offs == TMR_CTRL);
  assign wr_preset = wr_hit & (offs == TMR_PRESET);
  // Byte offset within a word carries no meaning: full-word accesses only
  assign unused_addr = ^bus.PrAddr[1:0];

  // Read mux: side-effect free, zero outside the window and at offset 3
  always_comb begin
    rd_data = '0;
    if (bus.Hit) begin
      case (offs)
        TMR_CTRL:   rd_data = {28'd0, ctrl_q};
        TMR_PRESET: rd_data = preset_q;
        TMR_COUNT:  rd_data = count_q;
        default:    rd_data = '0;
      endcase
    end
  end

  assign bus.PrRD = rd_data;
  assign IRQ      = irq_q;

  // Next state: FSM first, then bus writes override the FSM's En clear,
  // and a pending set beats a same-edge clear by a CTRL write.
  always_comb begin
    state_d      = state_q;
    ctrl_d       = ctrl_q;
    preset_d     = preset_q;
    count_d      = count_q;
    pend_d       = pend_q;
    fsm_clr_en   = 1'b0;
    fsm_set_pend = 1'b0;

    case (state_q)
      TMR_IDLE: begin
        if (ctrl_q.en) state_d = TMR_LOAD;
      end
      TMR_LOAD: begin
        count_d = preset_q;
        state_d = TMR_CNT;
      end
      TMR_CNT: begin
        if (!ctrl_q.en) begin
          state_d = TMR_IDLE;
        end else if (count_q <= 32'd1) begin
          // A preset of 0 expires on the first count edge, like a preset of 1
          count_d      = '0;
          fsm_set_pend = 1'b1;
          state_d      = TMR_INT;
        end else begin
          count_d = count_q - 32'd1;
        end
      end
      TMR_INT: begin
        if (is_reload(ctrl_q.mode)) begin
          state_d = TMR_LOAD;
        end else begin
          fsm_clr_en = 1'b1;
          state_d    = TMR_IDLE;
        end
      end
      default: state_d = TMR_IDLE;
    endcase

    if (fsm_clr_en) ctrl_d.en = 1'b0;

    if (wr_ctrl) begin
      ctrl_d.en   = bus.PrWD[CTRL_EN];
      ctrl_d.mode = bus.PrWD[CTRL_MODE_HI:CTRL_MODE_LO];
      ctrl_d.im   = bus.PrWD[CTRL_IM];
      pend_d      = 1'b0;
    end

    if (fsm_set_pend) pend_d = 1'b1;

    if (wr_preset) preset_d = bus.PrWD;

    // IRQ is computed from next-state values and flopped so it never glitches
    irq_d = pend_d & ctrl_d.im;
  end

  // State and register file; reset is immediate and clears everything
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= TMR_IDLE;
      ctrl_q   <= '0;
      preset_q <= '0;
      count_q  <= '0;
      pend_q   <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      pend_q   <= pend_d;
      irq_q    <= irq_d;
    end
  end

endmodule
